lif_array: RTL and testbench
============================

# lif_array

Parametrised bank of `N_CH` independent leaky integrate-and-fire neurons sharing one clock, one threshold and one step strobe. It is the multi-channel successor to the single 8-bit LIF neuron used at the chip top level. It adds the following:
- configurable width and leak;
- a refractory period;
- selectable reset-on-spike mode;
- a saturating membrane;
- a running spike counter.

It sits between the input current bus and the spike/state outputs of the top-level wrapper.

## Interface
Parameters:
- `N_CH`, 4, number of neuron channels (1..16)
- `W`, 8, membrane/current width in bits (4..16)
- `LEAK_SHIFT`, 1, leak as right shift of membrane per step (1..W-1)
- `REFRACT`, 2, refractory length in steps (0..15)
- `CNT_W`, 16, spike counter width

Ports:
- `clk`  in  1  clock. One clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `current`  in  N_CH*W  per-channel input current, unsigned; channel k at bits [k*W +: W]
- `threshold`  in  W  firing threshold, unsigned, shared by all channels
- `step_en`  in  1  advance all neurons by one time step this cycle
- `sub_mode`  in  1  0: membrane cleared to 0 on spike; 1: membrane reduced by threshold on spike
- `cnt_clr`  in  1  synchronous clear of `spike_count`
- `state`  out  N_CH*W  registered membrane potentials, same packing as `current`
- `spike`  out  N_CH  registered per-channel spike pulses
- `spike_count`  out  CNT_W  total spikes emitted since reset/clear, wraps modulo 2^CNT_W

## Operation
Per-channel registers:
- membrane `v` (W bits)
- refractory counter `r` (4 bits)
- spike flag

On a cycle with `step_en`=0:
- `v` and `r` hold.
- `spike` clears to 0.

On a cycle with `step_en`=1, for each channel:
- **Refractory (`r` != 0):**
  - `r` <= `r`-1
  - `v` <= 0
  - spike <= 0
  - `current` is ignored.
- **Integrate (`r` == 0):**
  - Compute `sum` = `current` + (`v` >> `LEAK_SHIFT`) in W+1 bits.
  - Saturate: `s` = (`sum` > 2^W-1) ? 2^W-1 : `sum`.
- **Fire, when `s` >= `threshold`:**
  - spike <= 1
  - `r` <= `REFRACT`
  - `v` <= (`sub_mode` ? `s` - `threshold` : 0)
- **No fire:**
  - spike <= 0
  - `v` <= `s`

Global rules:
- `threshold`=0 means every non-refractory step fires.
- `sub_mode` is sampled on the same edge as `step_en`.
- Spike counter:
  - `spike_count` <= `spike_count` + popcount(next spike vector) on each `step_en` cycle.
  - Wraps modulo 2^CNT_W.
  - `cnt_clr` has priority: counter <= 0 and that cycle's spikes are not counted.
- Channels are fully independent; any number may fire in the same step.

## Timing
- Reset (`rst_n`=0, asynchronous): all `v`=0, all `r`=0, `spike`=0, `spike_count`=0, immediately and held until release.
- Latency:
  - `state`/`spike` reflect the step one cycle after the `step_en` edge, with no combinational path from inputs to outputs.
  - `spike_count` updates on the same edge as `spike`.
- `spike` is a single-cycle pulse per firing step, even if `step_en` stays high on consecutive cycles. Consecutive steps may each fire only when `REFRACT`=0.
- `REFRACT`=R: after a spike, exactly R subsequent steps are refractory. The first possible re-fire is step R+1 after the firing step.
- Reset asserted mid-refractory or mid-integration clears everything. The first step after release integrates from 0.
- Back-to-back `step_en` is supported at full clock rate.

## Test plan
- **Reset and hold:**
  - Stimulus: reset asserted with `current`=all 0xFF, `step_en`=1.
  - Response: all outputs 0 throughout reset. After release with `step_en`=0, `state` remains 0.
- **Leak and integrate:**
  - Stimulus: `N_CH`=4, `W`=8, `LEAK_SHIFT`=1, `threshold`=200, ch0 `current`=40, steady steps.
  - Response: v = 40, 60, 70, 75, 77, 78, 79, 79, with no spike.
- **Fire / reset mode:**
  - Stimulus: `threshold`=100, `sub_mode`=0, ch1 `current`=60, `REFRACT`=2.
  - Response: v = 60, 90. Step 3 gives s=105 → spike=1 and v=0. Steps 4–5: v=0, no spike. Step 6: v=60.
- **Subtract mode and saturation:**
  - Stimulus: `threshold`=50, `sub_mode`=1, `REFRACT`=0, `current`=255, prior v=200.
  - Response: s saturates at 255, so spike=1 and v=205.
  - Stimulus: `threshold`=0.
  - Response: spike every step.
- **Counter and clear:**
  - Stimulus: all 4 channels fire in one step, then 2 fire.
  - Response: `spike_count` = 4, then 6. `cnt_clr` together with a 3-spike step gives 0. Preload counter to 0xFFFE then a 3-spike step gives 0x0001.
- **Async reset mid-refractory:**
  - Stimulus: pulse `rst_n` low between clock edges while `r`=2.
  - Response: outputs clear before the next edge. The first step after release integrates normally with no refractory hold.

Source files
------------

// File: rtl/lif_array.sv
// rtl/lif_array.sv - bank of N_CH leaky integrate-and-fire neurons with refractory hold,
// saturating membrane, selectable reset-on-spike mode and a shared running spike counter.
module lif_array #(
  parameter int N_CH       = 4,
  parameter int W          = 8,
  parameter int LEAK_SHIFT = 1,
  parameter int REFRACT    = 2,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH*W-1:0]   current,
  input  logic [W-1:0]        threshold,
  input  logic                step_en,
  input  logic                sub_mode,
  input  logic                cnt_clr,
  output logic [N_CH*W-1:0]   state,
  output logic [N_CH-1:0]     spike,
  output logic [CNT_W-1:0]    spike_count
);

  localparam logic [3:0]   REFRACT_V = 4'(REFRACT);
  localparam logic [W-1:0] V_MAX     = {W{1'b1}};

  logic [W-1:0]     v_q   [N_CH];
  logic [W-1:0]     v_d   [N_CH];
  logic [3:0]       r_q   [N_CH];
  logic [3:0]       r_d   [N_CH];
  logic [W:0]       sum   [N_CH];
  logic [W-1:0]     sat   [N_CH];
  logic [N_CH-1:0]  spike_q, spike_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, pop;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      v_d[k]     = v_q[k];
      r_d[k]     = r_q[k];
      spike_d[k] = 1'b0;
      sum[k]     = {1'b0, current[k*W +: W]} + {1'b0, v_q[k] >> LEAK_SHIFT};
      // The extra sum bit is the overflow flag: clamp rather than wrap.
      sat[k]     = sum[k][W] ? V_MAX : sum[k][W-1:0];
      if (step_en) begin
        if (r_q[k] != 4'd0) begin
          r_d[k] = r_q[k] - 4'd1;
          v_d[k] = '0;
        end else if (sat[k] >= threshold) begin
          spike_d[k] = 1'b1;
          r_d[k]     = REFRACT_V;
          v_d[k]     = sub_mode ? (sat[k] - threshold) : '0;
        end else begin
          v_d[k] = sat[k];
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int k = 0; k < N_CH; k++) begin
      pop = pop + CNT_W'(spike_d[k]);
    end
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (step_en) begin
      cnt_d = cnt_q + pop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) begin
        v_q[k] <= '0;
        r_q[k] <= '0;
      end
      spike_q <= '0;
      cnt_q   <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        v_q[k] <= v_d[k];
        r_q[k] <= r_d[k];
      end
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      state[k*W +: W] = v_q[k];
    end
  end

  assign spike       = spike_q;
  assign spike_count = cnt_q;

endmodule

// File: tb/tb_lif_array.sv
// tb/tb_lif_array.sv - self-checking bench for lif_array: directed scenarios plus randomized
// stimulus against an arithmetic reference model, on a REFRACT=2 and a REFRACT=0 instance.
module tb_lif_array;

  localparam int N_CH = 4;
  localparam int W    = 8;
  localparam int LS   = 1;
  localparam int CW   = 16;
  localparam int VMAX = (1 << W) - 1;

  logic              clk;
  logic              rst_n;
  logic [N_CH*W-1:0] current;
  logic [W-1:0]      threshold;
  logic              step_en;
  logic              sub_mode;
  logic              cnt_clr;
  logic [N_CH*W-1:0] state2, state0;
  logic [N_CH-1:0]   spike2, spike0;
  logic [CW-1:0]     cnt2, cnt0;

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 tracks u_r2 (REFRACT=2), index 1 tracks u_r0 (REFRACT=0).
  int mv   [2][N_CH];
  int mr   [2][N_CH];
  bit ms   [2][N_CH];
  int mcnt [2];
  int refr [2] = '{2, 0};

  lif_array #(.N_CH(N_CH), .W(W), .LEAK_SHIFT(LS), .REFRACT(2), .CNT_W(CW)) u_r2 (
    .clk(clk), .rst_n(rst_n), .current(current), .threshold(threshold),
    .step_en(step_en), .sub_mode(sub_mode), .cnt_clr(cnt_clr),
    .state(state2), .spike(spike2), .spike_count(cnt2)
  );

  lif_array #(.N_CH(N_CH), .W(W), .LEAK_SHIFT(LS), .REFRACT(0), .CNT_W(CW)) u_r0 (
    .clk(clk), .rst_n(rst_n), .current(current), .threshold(threshold),
    .step_en(step_en), .sub_mode(sub_mode), .cnt_clr(cnt_clr),
    .state(state0), .spike(spike0), .spike_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mcnt[d] = 0;
      for (int k = 0; k < N_CH; k++) begin
        mv[d][k] = 0;
        mr[d][k] = 0;
        ms[d][k] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    int s;
    int fired;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      fired = 0;
      for (int k = 0; k < N_CH; k++) begin
        if (!step_en) begin
          ms[d][k] = 1'b0;
        end else if (mr[d][k] > 0) begin
          mr[d][k] = mr[d][k] - 1;
          mv[d][k] = 0;
          ms[d][k] = 1'b0;
        end else begin
          s = int'(current[k*W +: W]) + mv[d][k] / (1 << LS);
          if (s > VMAX) s = VMAX;
          if (s >= int'(threshold)) begin
            ms[d][k] = 1'b1;
            mr[d][k] = refr[d];
            mv[d][k] = sub_mode ? s - int'(threshold) : 0;
            fired++;
          end else begin
            ms[d][k] = 1'b0;
            mv[d][k] = s;
          end
        end
      end
      if (cnt_clr) mcnt[d] = 0;
      else if (step_en) mcnt[d] = (mcnt[d] + fired) % (1 << CW);
    end
  endtask

  function automatic logic [N_CH*W-1:0] exp_state(int d);
    logic [N_CH*W-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k*W +: W] = W'(mv[d][k]);
    return r;
  endfunction

  function automatic logic [N_CH-1:0] exp_spike(int d);
    logic [N_CH-1:0] r;
    for (int k = 0; k < N_CH; k++) r[k] = ms[d][k];
    return r;
  endfunction

  // Advance model and DUT by one clock; returns #1 after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    step_en  = 1'b0;
    cnt_clr  = 1'b0;
    sub_mode = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_currents(int c0, int c1, int c2, int c3);
    current[0*W +: W] = W'(c0);
    current[1*W +: W] = W'(c1);
    current[2*W +: W] = W'(c2);
    current[3*W +: W] = W'(c3);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    current   = '1;
    step_en   = 1'b1;
    threshold = '0;
    sub_mode  = 1'b0;
    cnt_clr   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({state2, spike2, cnt2, state0, spike0, cnt0} !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: state2=%h spike2=%h cnt2=%h state0=%h spike0=%h cnt0=%h required all 0",
                 i, state2, spike2, cnt2, state0, spike0, cnt0);
      end
    end
    step_en = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (state2 !== '0 || state0 !== '0) begin
        errors++;
        $display("FAIL reset_release cycle %0d: state2=%h state0=%h required 0", i, state2, state0);
      end
    end
  endtask

  task automatic test_leak();
    int exp_v [8] = '{40, 60, 70, 75, 77, 78, 79, 79};
    apply_reset();
    threshold = 8'd200;
    set_currents(40, 0, 0, 0);
    step_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (state2[0 +: W] !== W'(exp_v[i]) || spike2 !== '0) begin
        errors++;
        $display("FAIL leak step %0d: v=%0d spike=%b required v=%0d spike=0000",
                 i + 1, state2[0 +: W], spike2, exp_v[i]);
      end
    end
    step_en = 1'b0;
  endtask

  task automatic test_fire_reset_mode();
    int exp_v [6] = '{60, 90, 0, 0, 0, 60};
    bit exp_s [6] = '{0, 0, 1, 0, 0, 0};
    apply_reset();
    threshold = 8'd100;
    sub_mode  = 1'b0;
    set_currents(0, 60, 0, 0);
    step_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (state2[1*W +: W] !== W'(exp_v[i]) || spike2[1] !== exp_s[i]) begin
        errors++;
        $display("FAIL fire_reset step %0d: v=%0d spike=%b required v=%0d spike=%b",
                 i + 1, state2[1*W +: W], spike2[1], exp_v[i], exp_s[i]);
      end
    end
    step_en = 1'b0;
    tick();
    checks++;
    if (spike2 !== '0 || state2[1*W +: W] !== 8'd60) begin
      errors++;
      $display("FAIL fire_hold: spike=%b v=%0d required spike=0000 v=60", spike2, state2[1*W +: W]);
    end
  endtask

  task automatic test_sub_sat();
    apply_reset();
    threshold = 8'd250;
    set_currents(200, 0, 0, 0);
    step_en = 1'b1;
    tick();
    threshold = 8'd50;
    sub_mode  = 1'b1;
    set_currents(255, 0, 0, 0);
    tick();
    checks++;
    if (state0[0 +: W] !== 8'd205 || spike0[0] !== 1'b1 ||
        state2[0 +: W] !== 8'd205 || spike2[0] !== 1'b1) begin
      errors++;
      $display("FAIL sub_sat: r0 v=%0d spike=%b r2 v=%0d spike=%b required v=205 spike=1",
               state0[0 +: W], spike0[0], state2[0 +: W], spike2[0]);
    end
    threshold = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (spike0 !== 4'hF) begin
        errors++;
        $display("FAIL thr_zero step %0d: spike=%b required 1111", i, spike0);
      end
    end
    step_en  = 1'b0;
    sub_mode = 1'b0;
  endtask

  task automatic test_counter();
    apply_reset();
    step_en   = 1'b1;
    threshold = 8'd0;
    set_currents(0, 0, 0, 0);
    tick();
    checks++;
    if (cnt0 !== 16'd4) begin
      errors++;
      $display("FAIL count_four: count=%0d required 4", cnt0);
    end
    threshold = 8'd1;
    set_currents(255, 255, 0, 0);
    tick();
    checks++;
    if (cnt0 !== 16'd6) begin
      errors++;
      $display("FAIL count_six: count=%0d required 6", cnt0);
    end
    cnt_clr = 1'b1;
    set_currents(255, 255, 255, 0);
    tick();
    checks++;
    if (cnt0 !== 16'd0 || spike0 !== 4'b0111) begin
      errors++;
      $display("FAIL count_clr: count=%0d spike=%b required count=0 spike=0111", cnt0, spike0);
    end
    cnt_clr   = 1'b0;
    threshold = 8'd0;
    for (int i = 0; i < 16383; i++) tick();
    threshold = 8'd1;
    set_currents(255, 255, 0, 0);
    tick();
    checks++;
    if (cnt0 !== 16'hFFFE) begin
      errors++;
      $display("FAIL count_preload: count=%h required fffe", cnt0);
    end
    set_currents(255, 255, 255, 0);
    tick();
    checks++;
    if (cnt0 !== 16'h0001) begin
      errors++;
      $display("FAIL count_wrap: count=%h required 0001", cnt0);
    end
    step_en = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset();
    threshold = 8'd0;
    sub_mode  = 1'b0;
    set_currents(0, 0, 0, 0);
    step_en = 1'b1;
    tick();
    checks++;
    if (spike2 !== 4'hF) begin
      errors++;
      $display("FAIL async_prefire: spike=%b required 1111", spike2);
    end
    step_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({state2, spike2, cnt2} !== '0) begin
      errors++;
      $display("FAIL async_clear: state=%h spike=%b count=%0d required 0", state2, spike2, cnt2);
    end
    #1 rst_n = 1'b1;
    model_reset();
    threshold = 8'd100;
    set_currents(0, 60, 0, 0);
    step_en = 1'b1;
    tick();
    checks++;
    if (state2[1*W +: W] !== 8'd60 || spike2 !== '0) begin
      errors++;
      $display("FAIL async_first_step: v=%0d spike=%b required v=60 spike=0000",
               state2[1*W +: W], spike2);
    end
    step_en = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      current   = N_CH*W'($urandom);
      threshold = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      step_en   = ($urandom_range(0, 3) != 0);
      sub_mode  = 1'($urandom);
      cnt_clr   = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if (state2 !== exp_state(0) || spike2 !== exp_spike(0) || cnt2 !== CW'(mcnt[0])) begin
        errors++;
        $display("FAIL random_r2 cycle %0d: state=%h spike=%b count=%0d required state=%h spike=%b count=%0d",
                 i, state2, spike2, cnt2, exp_state(0), exp_spike(0), mcnt[0]);
      end
      checks++;
      if (state0 !== exp_state(1) || spike0 !== exp_spike(1) || cnt0 !== CW'(mcnt[1])) begin
        errors++;
        $display("FAIL random_r0 cycle %0d: state=%h spike=%b count=%0d required state=%h spike=%b count=%0d",
                 i, state0, spike0, cnt0, exp_state(1), exp_spike(1), mcnt[1]);
      end
    end
    cnt_clr = 1'b0;
    step_en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_leak();
    test_fire_reset_mode();
    test_sub_sat();
    test_counter();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
